// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, control-word
// bit positions, trap causes and FSM state encoding.
package seq_pkg;

  // Opcode field values (instruction bits [15:10])
  localparam logic [5:0] OP_BRZ = 6'h00;
  localparam logic [5:0] OP_BRN = 6'h01;
  localparam logic [5:0] OP_BRC = 6'h02;
  localparam logic [5:0] OP_BRO = 6'h03;
  localparam logic [5:0] OP_LD  = 6'h04;
  localparam logic [5:0] OP_ST  = 6'h05;
  localparam logic [5:0] OP_BRA = 6'h06;
  localparam logic [5:0] OP_JMP = 6'h07;
  localparam logic [5:0] OP_RET = 6'h08;
  localparam logic [5:0] OP_ADD = 6'h09;
  localparam logic [5:0] OP_MOV = 6'h0A;
  localparam logic [5:0] OP_SUB = 6'h0B;
  localparam logic [5:0] OP_INC = 6'h0C;
  localparam logic [5:0] OP_DEC = 6'h0D;

  // Control-word bit positions as returned by the control unit
  localparam int CB_NEXT = 7;
  localparam int CB_BR   = 6;
  localparam int CB_ALU  = 5;
  localparam int CB_LSE  = 4;
  localparam int CB_LDM  = 3;
  localparam int CB_LACC = 2;
  localparam int CB_ABS  = 1;
  localparam int CB_SPO  = 0;

  // The CU answers all-ones for opcodes it does not recognise
  localparam logic [7:0] CW_ILLEGAL = 8'hFF;

  typedef enum logic [1:0] {
    TRAP_NONE      = 2'b00,
    TRAP_ILLEGAL   = 2'b01,
    TRAP_OVERFLOW  = 2'b10,
    TRAP_UNDERFLOW = 2'b11
  } trap_t;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_TRAP   = 2'b11
  } state_t;

  // A control word is unusable if it is the illegal marker or lacks "next"
  function automatic logic cw_is_illegal(input logic [7:0] cw);
    return (cw == CW_ILLEGAL) || (cw[CB_NEXT] == 1'b0);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Hardware return stack: DEPTH x W LIFO used by jmp/ret.
// Push and pop are never requested in the same cycle by the sequencer;
// an ignored push when full or pop when empty leaves the stack unchanged.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW:0]   cnt_r;
  logic [AW-1:0] top_idx_s;

  assign full      = (cnt_r == FULL_CNT);
  assign empty     = (cnt_r == {(AW+1){1'b0}});
  assign top_idx_s = cnt_r[AW-1:0] - AW'(1);
  assign top       = mem_r[top_idx_s];

  // Occupancy count: grows on accepted push, shrinks on accepted pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {(AW+1){1'b0}};
    end else if (push && !full) begin
      cnt_r <= cnt_r + (AW+1)'(1);
    end else if (pop && !empty) begin
      cnt_r <= cnt_r - (AW+1)'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Storage: write the pushed return address into the next free slot
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[cnt_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: fetches an instruction, hands its opcode to the
// control unit, then issues one cycle of execute strobes and updates the PC
// (sequential, branch, call/return). Faults park the block in TRAP.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int RS_DEPTH = 8,
  parameter int CU_LAT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [5:0]      op_code,
  input  logic [7:0]      ctrl_word,
  input  logic            flag_z,
  input  logic            flag_n,
  input  logic            flag_c,
  input  logic            flag_v,
  output logic [PC_W-1:0] operand,
  output logic            alu_start,
  output logic            load_en,
  output logic            store_en,
  output logic            acc_we,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [1:0]      trap_cause
);

  // Last DECODE count before the control word is sampled
  localparam logic [1:0] CNT_LAST = 2'(CU_LAT - 1);

  state_t          state_r;
  logic [1:0]      cnt_r;
  logic            br_r;

  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] next_pc_s;
  logic            push_s;
  logic            pop_s;
  logic            exec_trap_s;
  trap_t           exec_cause_s;
  logic [PC_W-1:0] rs_top_s;
  logic            rs_full_s;
  logic            rs_empty_s;

  assign imem_addr = pc;

  ret_stack #(
    .DEPTH (RS_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pc_inc_s),
    .top   (rs_top_s),
    .full  (rs_full_s),
    .empty (rs_empty_s)
  );

  // Next-PC, stack requests and execute-time faults; flags only matter in EXEC
  always_comb begin
    pc_inc_s     = pc + PC_W'(1);
    next_pc_s    = pc_inc_s;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    exec_trap_s  = 1'b0;
    exec_cause_s = TRAP_NONE;
    if ((state_r == ST_EXEC) && br_r) begin
      case (op_code)
        OP_BRZ: if (flag_z) next_pc_s = operand; else next_pc_s = pc_inc_s;
        OP_BRN: if (flag_n) next_pc_s = operand; else next_pc_s = pc_inc_s;
        OP_BRC: if (flag_c) next_pc_s = operand; else next_pc_s = pc_inc_s;
        OP_BRO: if (flag_v) next_pc_s = operand; else next_pc_s = pc_inc_s;
        OP_BRA: next_pc_s = operand;
        OP_JMP: begin
          if (rs_full_s) begin
            exec_trap_s  = 1'b1;
            exec_cause_s = TRAP_OVERFLOW;
            next_pc_s    = pc;
          end else begin
            push_s    = 1'b1;
            next_pc_s = operand;
          end
        end
        OP_RET: begin
          if (rs_empty_s) begin
            exec_trap_s  = 1'b1;
            exec_cause_s = TRAP_UNDERFLOW;
            next_pc_s    = pc;
          end else begin
            pop_s     = 1'b1;
            next_pc_s = rs_top_s;
          end
        end
        default: next_pc_s = pc_inc_s;
      endcase
    end else begin
      next_pc_s = pc_inc_s;
    end
  end

  // Sequencer FSM with registered fetch, opcode, strobe and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      cnt_r      <= 2'd0;
      br_r       <= 1'b0;
      pc         <= '0;
      imem_req   <= 1'b0;
      op_code    <= 6'd0;
      operand    <= '0;
      alu_start  <= 1'b0;
      load_en    <= 1'b0;
      store_en   <= 1'b0;
      acc_we     <= 1'b0;
      halted     <= 1'b0;
      trap_cause <= TRAP_NONE;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_valid) begin
            op_code  <= imem_rdata[15:10];
            operand  <= imem_rdata[PC_W-1:0];
            imem_req <= 1'b0;
            cnt_r    <= 2'd0;
            state_r  <= ST_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (cnt_r == CNT_LAST) begin
            if (cw_is_illegal(ctrl_word)) begin
              halted     <= 1'b1;
              trap_cause <= TRAP_ILLEGAL;
              state_r    <= ST_TRAP;
            end else begin
              br_r      <= ctrl_word[CB_BR];
              alu_start <= ctrl_word[CB_ALU];
              load_en   <= ctrl_word[CB_LSE] & ctrl_word[CB_LDM];
              store_en  <= (op_code == OP_ST);
              acc_we    <= ctrl_word[CB_LACC];
              state_r   <= ST_EXEC;
            end
          end else begin
            cnt_r <= cnt_r + 2'd1;
          end
        end
        ST_EXEC: begin
          alu_start <= 1'b0;
          load_en   <= 1'b0;
          store_en  <= 1'b0;
          acc_we    <= 1'b0;
          if (exec_trap_s) begin
            halted     <= 1'b1;
            trap_cause <= exec_cause_s;
            state_r    <= ST_TRAP;
          end else begin
            pc       <= next_pc_s;
            imem_req <= 1'b1;
            state_r  <= ST_FETCH;
          end
        end
        ST_TRAP: begin
          halted    <= 1'b1;
          imem_req  <= 1'b0;
          alu_start <= 1'b0;
          load_en   <= 1'b0;
          store_en  <= 1'b0;
          acc_we    <= 1'b0;
        end
        default: begin
          halted     <= 1'b1;
          imem_req   <= 1'b0;
          trap_cause <= TRAP_ILLEGAL;
          state_r    <= ST_TRAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer (CU_LAT=3). Each test loads a small
// program, queues the expected fetch/halt events, and a monitor compares
// every fetch start or halt the DUT presents against the queue.
module tb_instr_sequencer;

  localparam int PC_W   = 10;
  localparam int CU_LAT = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic [15:0]     imem_rdata = 16'h0000;
  logic            imem_valid = 1'b0;
  logic [5:0]      op_code;
  logic [7:0]      ctrl_word;
  logic            flag_z = 1'b0, flag_n = 1'b0, flag_c = 1'b0, flag_v = 1'b0;
  logic [PC_W-1:0] operand;
  logic            alu_start, load_en, store_en, acc_we;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic [1:0]      trap_cause;

  typedef struct packed {
    logic       halt;
    logic [9:0] addr;
    logic [3:0] smask;  // {alu_start, load_en, store_en, acc_we} seen
    logic [2:0] scyc;   // cycles with any strobe high
    logic [3:0] gap;    // cycles with neither fetch nor halt
    logic [1:0] opchg;  // op_code changes inside the gap
    logic [1:0] cause;
    logic       req;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] prog [0:1023];

  instr_sequencer #(.PC_W(PC_W), .RS_DEPTH(8), .CU_LAT(CU_LAT)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .op_code(op_code),
    .ctrl_word(ctrl_word), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .operand(operand), .alu_start(alu_start),
    .load_en(load_en), .store_en(store_en), .acc_we(acc_we), .pc(pc),
    .halted(halted), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // Control-unit model
  function automatic logic [7:0] cu_model(input logic [5:0] op);
    case (op)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h06, 6'h07, 6'h08: return 8'hC0;
      6'h04:   return 8'h9C;  // ld : lse, ldm, lacc
      6'h05:   return 8'h90;  // st : lse
      6'h09:   return 8'hA4;  // add: aluOp, lacc
      6'h0A:   return 8'h84;  // mov: lacc
      6'h3F:   return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  assign ctrl_word = cu_model(op_code);

  // Instruction memory: valid on the second cycle of a request
  initial begin
    int mcnt;
    mcnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !imem_req) begin
        mcnt = 0;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
      end else begin
        mcnt++;
        if (mcnt >= 2) begin
          imem_valid = 1'b1;
          imem_rdata = prog[imem_addr];
        end else begin
          imem_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: an event is a rising imem_req (new fetch) or a rising halted
  initial begin
    logic prev_req, prev_halt, prev_gap, in_gap;
    logic [5:0] prev_op;
    int acc_gap, acc_scyc, acc_opchg;
    logic [3:0] acc_mask;
    ev_t act, e;
    prev_req = 1'b0; prev_halt = 1'b0; prev_gap = 1'b0; prev_op = 6'd0;
    acc_gap = 0; acc_scyc = 0; acc_opchg = 0; acc_mask = 4'b0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0; prev_halt = 1'b0; prev_gap = 1'b0; prev_op = 6'd0;
        acc_gap = 0; acc_scyc = 0; acc_opchg = 0; acc_mask = 4'b0000;
      end else begin
        if ((imem_req && !prev_req) || (halted && !prev_halt)) begin
          act       = '0;
          act.halt  = halted;
          act.addr  = halted ? pc : imem_addr;
          act.smask = acc_mask;
          act.scyc  = (acc_scyc > 7) ? 3'd7 : 3'(acc_scyc);
          act.gap   = (acc_gap > 15) ? 4'd15 : 4'(acc_gap);
          act.opchg = (acc_opchg > 3) ? 2'd3 : 2'(acc_opchg);
          act.cause = trap_cause;
          act.req   = imem_req;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got halt=%0b addr=%h, required no event",
                     act.halt, act.addr);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              errors++;
              $display("FAIL event: got halt=%0b addr=%h smask=%b scyc=%0d gap=%0d opchg=%0d cause=%0d req=%0b, required halt=%0b addr=%h smask=%b scyc=%0d gap=%0d opchg=%0d cause=%0d req=%0b",
                       act.halt, act.addr, act.smask, act.scyc, act.gap, act.opchg, act.cause, act.req,
                       e.halt, e.addr, e.smask, e.scyc, e.gap, e.opchg, e.cause, e.req);
            end
          end
          acc_gap = 0; acc_scyc = 0; acc_opchg = 0; acc_mask = 4'b0000;
        end
        in_gap = !imem_req && !halted;
        if (in_gap) acc_gap++;
        if (in_gap && prev_gap && (op_code != prev_op)) acc_opchg++;
        if (alu_start || load_en || store_en || acc_we) acc_scyc++;
        acc_mask = acc_mask | {alu_start, load_en, store_en, acc_we};
        prev_req = imem_req; prev_halt = halted; prev_gap = in_gap; prev_op = op_code;
      end
    end
  end

  function automatic void exp_fetch(input logic [9:0] addr, input logic [3:0] smask,
                                    input logic [3:0] gap);
    ev_t e;
    e = '0;
    e.addr  = addr;
    e.smask = smask;
    e.scyc  = (smask != 4'b0000) ? 3'd1 : 3'd0;
    e.gap   = gap;
    e.req   = 1'b1;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_halt(input logic [9:0] addr, input logic [1:0] cause,
                                   input logic [3:0] gap);
    ev_t e;
    e = '0;
    e.halt  = 1'b1;
    e.addr  = addr;
    e.cause = cause;
    e.gap   = gap;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic begin_test();
    rst = 1'b1;
    {flag_v, flag_c, flag_n, flag_z} = 4'b0000;
    for (int i = 0; i < 1024; i++) prog[i] = 16'hFC00;
    exp_q.delete();
    @(posedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || !halted) && (n < 600)) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if ((exp_q.size() != 0) || !halted) begin
      errors++;
      $display("FAIL %s_done: got pending=%0d halted=%0b, required pending=0 halted=1",
               name, exp_q.size(), halted);
    end
  endtask

  initial begin
    logic [3:0] fl;
    logic [9:0] tgt;
    int n;

    // Reset values
    for (int i = 0; i < 1024; i++) prog[i] = 16'hFC00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({imem_addr, pc, op_code, operand, imem_req, halted, trap_cause,
             alu_start, load_en, store_en, acc_we}), 64'h0);

    // add, st, ld then illegal at 3
    begin_test();
    prog[0] = 16'h2405; prog[1] = 16'h1405; prog[2] = 16'h1007;
    exp_fetch(10'h000, 4'b0000, 4'd1);
    exp_fetch(10'h001, 4'b1001, 4'd4);
    exp_fetch(10'h002, 4'b0010, 4'd4);
    exp_fetch(10'h003, 4'b0101, 4'd4);
    exp_halt(10'h003, 2'b01, 4'd3);
    release_rst();
    wait_done("add_st_ld");

    // Conditional branches at pc=4, taken with own flag, not taken with the others
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 2; t++) begin
        begin_test();
        prog[0] = 16'h1804;
        prog[4] = {6'(k), 10'h030};
        fl = 4'b0001 << k;
        if (t == 1) fl = ~fl;
        {flag_v, flag_c, flag_n, flag_z} = fl;
        tgt = (t == 0) ? 10'h030 : 10'h005;
        exp_fetch(10'h000, 4'b0000, 4'd1);
        exp_fetch(10'h004, 4'b0000, 4'd4);
        exp_fetch(tgt, 4'b0000, 4'd4);
        exp_halt(tgt, 2'b01, 4'd3);
        release_rst();
        wait_done("branch");
      end
    end

    // jmp 0x100 at 0x020, ret back to 0x021, second ret underflows
    begin_test();
    prog[10'h000] = 16'h1820; prog[10'h020] = 16'h1D00;
    prog[10'h100] = 16'h2000; prog[10'h021] = 16'h2000;
    exp_fetch(10'h000, 4'b0000, 4'd1);
    exp_fetch(10'h020, 4'b0000, 4'd4);
    exp_fetch(10'h100, 4'b0000, 4'd4);
    exp_fetch(10'h021, 4'b0000, 4'd4);
    exp_halt(10'h021, 2'b11, 4'd4);
    release_rst();
    wait_done("jmp_ret");

    // Nine nested jmp: the ninth overflows at pc 8
    begin_test();
    for (int i = 0; i < 9; i++) prog[i] = 16'h1C00 | 16'(i + 1);
    exp_fetch(10'h000, 4'b0000, 4'd1);
    for (int i = 1; i < 9; i++) exp_fetch(10'(i), 4'b0000, 4'd4);
    exp_halt(10'h008, 2'b10, 4'd4);
    release_rst();
    wait_done("overflow");

    // ret straight after reset underflows
    begin_test();
    prog[0] = 16'h2000;
    exp_fetch(10'h000, 4'b0000, 4'd1);
    exp_halt(10'h000, 2'b11, 4'd4);
    release_rst();
    wait_done("underflow");

    // Opcode 111111 and a control word without "next" are both illegal
    begin_test();
    exp_fetch(10'h000, 4'b0000, 4'd1);
    exp_halt(10'h000, 2'b01, 4'd3);
    release_rst();
    wait_done("illegal_ff");

    begin_test();
    prog[0] = 16'h8000;
    exp_fetch(10'h000, 4'b0000, 4'd1);
    exp_halt(10'h000, 2'b01, 4'd3);
    release_rst();
    wait_done("illegal_next0");

    // mov at 0x3FF wraps pc to 0
    begin_test();
    prog[10'h000] = 16'h1BFF; prog[10'h3FF] = 16'h2800;
    exp_fetch(10'h000, 4'b0000, 4'd1);
    exp_fetch(10'h3FF, 4'b0000, 4'd4);
    exp_fetch(10'h000, 4'b0001, 4'd4);
    exp_halt(10'h000, 2'b01, 4'd3);
    release_rst();
    n = 0;
    while (!(imem_req && (imem_addr == 10'h3FF)) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    chk("reach_3ff", 64'(imem_addr), 64'h3FF);
    prog[10'h000] = 16'hFC00;
    wait_done("wrap");

    // Asynchronous reset mid-fetch with imem_valid pending
    begin_test();
    prog[10'h000] = 16'h1820;
    exp_fetch(10'h000, 4'b0000, 4'd1);
    exp_fetch(10'h020, 4'b0000, 4'd4);
    release_rst();
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(imem_req && imem_valid && (imem_addr == 10'h020)) && (n < 200));
    chk("pending_fetch_0x20", 64'({imem_req, imem_valid, imem_addr}), 64'({2'b11, 10'h020}));
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        64'({imem_addr, pc, op_code, operand, imem_req, halted, trap_cause,
             alu_start, load_en, store_en, acc_we}), 64'h0);
    chk("reset_pending_events", 64'(exp_q.size()), 64'h0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
